// File: rtl/sqrt_iter_sequencer.sv
// ============================================================================
// sqrt_iter_sequencer : FP square-root control sequencer (INIT0, INIT1, N x NR, OUT)
// Optional macro SQRT_SEQ_CTRL_REG_EN registers the outputs.   Revision: 1.0
// ============================================================================
`default_nettype none

module sqrt_iter_sequencer #(
  parameter int                CTRL_W   = 14,
  parameter int                MAX_ITER = 16,
  parameter int                ITER_W   = $clog2(MAX_ITER + 1),
  parameter logic [CTRL_W-1:0] W_INIT0  = 14'b11001000000000,
  parameter logic [CTRL_W-1:0] W_INIT1  = 14'b01010001000000,
  parameter logic [CTRL_W-1:0] W_STEP0  = 14'b01011001010100,
  parameter logic [CTRL_W-1:0] W_STEP1  = 14'b01011011010000,
  parameter logic [CTRL_W-1:0] W_STEP2  = 14'b01011011101100,
  parameter logic [CTRL_W-1:0] W_STEP3  = 14'b01010011000000,
  parameter logic [CTRL_W-1:0] W_OUT    = 14'b00111011000001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ITER_W-1:0] iter_i,
  input  logic              stall_i,
  input  logic              abort_i,
  output logic [CTRL_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT0 = 3'd1,
    S_INIT1 = 3'd2,
    S_ITER  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [ITER_W-1:0] MAX_N = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ONE_N = ITER_W'(1);

  state_t            state, nxt_state;
  logic [1:0]        step, nxt_step;
  logic [ITER_W-1:0] iter_cnt, nxt_cnt;
  logic [ITER_W-1:0] n_lat, nxt_n;
  logic [ITER_W-1:0] n_clamped;

  function automatic logic [CTRL_W-1:0] word_of(input state_t st, input logic [1:0] stp);
    logic [CTRL_W-1:0] w;
    w = '0;
    case (st)
      S_INIT0: w = W_INIT0;
      S_INIT1: w = W_INIT1;
      S_ITER: begin
        case (stp)
          2'd0:    w = W_STEP0;
          2'd1:    w = W_STEP1;
          2'd2:    w = W_STEP2;
          default: w = W_STEP3;
        endcase
      end
      S_OUT:   w = W_OUT;
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    if (iter_i == '0) begin
      n_clamped = ONE_N;
    end else if (iter_i > MAX_N) begin
      n_clamped = MAX_N;
    end else begin
      n_clamped = iter_i;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    nxt_cnt   = iter_cnt;
    nxt_n     = n_lat;
    if (state != S_IDLE && abort_i) begin
      nxt_state = S_IDLE;
      nxt_step  = 2'd0;
      nxt_cnt   = '0;
    end else if (state == S_IDLE) begin
      if (start_i) begin
        nxt_state = S_INIT0;
        nxt_n     = n_clamped;
        nxt_step  = 2'd0;
        nxt_cnt   = '0;
      end
    end else if (!stall_i) begin
      case (state)
        S_INIT0: nxt_state = S_INIT1;
        S_INIT1: begin
          nxt_state = S_ITER;
          nxt_step  = 2'd0;
          nxt_cnt   = ONE_N;
        end
        S_ITER: begin
          // The final iteration skips its feedback step and goes straight to OUT.
          if (step == 2'd2 && iter_cnt == n_lat) begin
            nxt_state = S_OUT;
            nxt_step  = 2'd0;
          end else if (step == 2'd3) begin
            nxt_step = 2'd0;
            nxt_cnt  = iter_cnt + ONE_N;
          end else begin
            nxt_step = step + 2'd1;
          end
        end
        S_OUT: begin
          nxt_state = S_IDLE;
          nxt_step  = 2'd0;
          nxt_cnt   = '0;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

`ifdef SQRT_SEQ_CTRL_REG_EN
  logic [CTRL_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step     <= 2'd0;
      iter_cnt <= '0;
      n_lat    <= '0;
`ifdef SQRT_SEQ_CTRL_REG_EN
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`endif
    end else begin
      state    <= nxt_state;
      step     <= nxt_step;
      iter_cnt <= nxt_cnt;
      n_lat    <= nxt_n;
`ifdef SQRT_SEQ_CTRL_REG_EN
      // Decoding the next state keeps the registered outputs aligned with the state.
      data_q   <= word_of(nxt_state, nxt_step);
      busy_q   <= (nxt_state != S_IDLE);
      done_q   <= (nxt_state == S_OUT);
`endif
    end
  end

`ifdef SQRT_SEQ_CTRL_REG_EN
  assign data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
`else
  assign data_o = word_of(state, step);
  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_OUT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_sqrt_iter_sequencer.sv
// ============================================================================
// tb_sqrt_iter_sequencer : scoreboard bench for sqrt_iter_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sqrt_iter_sequencer;

  localparam logic [13:0] W_INIT0 = 14'b11001000000000;
  localparam logic [13:0] W_INIT1 = 14'b01010001000000;
  localparam logic [13:0] W_STEP0 = 14'b01011001010100;
  localparam logic [13:0] W_STEP1 = 14'b01011011010000;
  localparam logic [13:0] W_STEP2 = 14'b01011011101100;
  localparam logic [13:0] W_STEP3 = 14'b01010011000000;
  localparam logic [13:0] W_OUT   = 14'b00111011000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  iter_i = '0;
  logic        stall_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [13:0] data_o;
  logic        busy_o;
  logic        done_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Each entry is {busy, done, word} expected for one displayed cycle.
  logic [15:0] sb[$];

  sqrt_iter_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .iter_i  (iter_i),
    .stall_i (stall_i),
    .abort_i (abort_i),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic b, input logic d, input logic [13:0] w);
    sb.push_back({b, d, w});
  endtask

  // Expected stream starting with the IDLE cycle in which start is driven.
  task automatic push_seq(input int n, input bit stall3);
    int nn;
    nn = (n < 1) ? 1 : ((n > 16) ? 16 : n);
    push(1'b0, 1'b0, 14'd0);
    push(1'b1, 1'b0, W_INIT0);
    push(1'b1, 1'b0, W_INIT1);
    for (int it = 1; it <= nn; it++) begin
      push(1'b1, 1'b0, W_STEP0);
      push(1'b1, 1'b0, W_STEP1);
      push(1'b1, 1'b0, W_STEP2);
      if (stall3 && it == 2) begin
        repeat (3) push(1'b1, 1'b0, W_STEP2);
      end
      if (it < nn) push(1'b1, 1'b0, W_STEP3);
    end
    push(1'b1, 1'b1, W_OUT);
  endtask

  task automatic drive(input logic s, input logic [4:0] it, input logic st, input logic ab);
    @(posedge clk);
    #1;
    start_i = s;
    iter_i  = it;
    stall_i = st;
    abort_i = ab;
  endtask

  task automatic sample(input string tag);
    logic [15:0] e;
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : 16'h0000;
    check(tag, {16'h0, busy_o, done_o, data_o}, {16'h0, e});
  endtask

  task automatic run_op(input int n, input string tag);
    int nn;
    nn = (n < 1) ? 1 : ((n > 16) ? 16 : n);
    drive(1'b1, 5'(n), 1'b0, 1'b0);
    push_seq(n, 1'b0);
    sample(tag);
    repeat (4 * nn + 2) begin
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      sample(tag);
    end
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    sample({tag, "_idle"});
  endtask

  initial begin
    #12;
    check("rst_data", {18'h0, data_o}, 32'h0);
    check("rst_flags", {30'h0, busy_o, done_o}, 32'h0);
    rst_n = 1'b1;
    repeat (2) begin
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      sample("post_rst_idle");
    end

    // Reset in the middle of ITER must clear the outputs without a clock.
    drive(1'b1, 5'd4, 1'b0, 1'b0);
    push_seq(4, 1'b0);
    sample("pre_rst");
    repeat (7) begin
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      sample("pre_rst");
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", {18'h0, data_o}, 32'h0);
    check("async_rst_flags", {30'h0, busy_o, done_o}, 32'h0);
    sb.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) begin
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      sample("after_rst_idle");
    end

    run_op(11, "n11");
    run_op(1, "n1");
    run_op(0, "n0");
    run_op(20, "n20");

    // Stall during step 2 of the second iteration holds that word three extra cycles.
    drive(1'b1, 5'd3, 1'b0, 1'b0);
    push_seq(3, 1'b1);
    sample("stall");
    for (int j = 1; j <= 17; j++) begin
      drive(1'b0, 5'd0, (j >= 9 && j <= 11), 1'b0);
      sample("stall");
    end
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    sample("stall_idle");

    // Abort during INIT1 wins over stall; no OUT follows.
    drive(1'b1, 5'd5, 1'b0, 1'b0);
    push(1'b0, 1'b0, 14'd0);
    push(1'b1, 1'b0, W_INIT0);
    push(1'b1, 1'b0, W_INIT1);
    sample("abort");
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    sample("abort");
    drive(1'b0, 5'd0, 1'b1, 1'b1);
    sample("abort");
    repeat (2) begin
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      sample("abort_idle");
    end

    // Restart after abort; stall in IDLE must not block the start.
    drive(1'b1, 5'd2, 1'b1, 1'b0);
    push_seq(2, 1'b0);
    sample("restart");
    repeat (10) begin
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      sample("restart");
    end

    // Start held high: ignored while busy, re-accepted in the IDLE after OUT.
    drive(1'b1, 5'd2, 1'b0, 1'b0);
    push_seq(2, 1'b0);
    sample("hold");
    for (int j = 1; j <= 10; j++) begin
      drive(1'b1, 5'd7, 1'b0, 1'b0);
      sample("hold");
    end
    drive(1'b1, 5'd3, 1'b0, 1'b0);
    push_seq(3, 1'b0);
    sample("hold_reaccept");
    repeat (14) begin
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      sample("hold_second");
    end
    repeat (2) begin
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      sample("final_idle");
    end

    check("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
